// File: rtl/fyra_pkg.sv
// Shared types and encodings for the fyra 4-stage core control path.
package fyra_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  // Writeback source select carried with each instruction.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when an enabled source operand names the given destination register.
  function automatic logic srcMatch(input logic useReg, input logic [4:0] rs,
                                    input logic [4:0] rd);
    return useReg & (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the IE instruction is a load whose destination
// is read by the instruction currently in ID.
module hazard_detect
  import fyra_pkg::*;
(
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       idUseRs1,
  input  logic       idUseRs2,
  input  logic [4:0] ieRd,
  input  logic       ieRegWR,
  input  logic [1:0] ieWbCtrl,
  output logic       luHaz
);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    luHaz = ieRegWR && (ieWbCtrl == WB_MEM) && (ieRd != REG_X0) &&
            (srcMatch(idUseRs1, idRs1, ieRd) || srcMatch(idUseRs2, idRs2, ieRd));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the IF/ID/IE/DWB core: PC enable plus
// enable/flush of the pipeline registers for load-use stalls, taken-branch
// flushes and data-memory wait freezes.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush/freeze cycle
// counters; without it the counter ports read 0.
module pipe_ctrl
  import fyra_pkg::*;
#(
  parameter int unsigned LOAD_STALL  = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  idRs1,
  input  logic [4:0]  idRs2,
  input  logic        idUseRs1,
  input  logic        idUseRs2,
  input  logic [4:0]  ieRd,
  input  logic        ieRegWR,
  input  logic [1:0]  ieWbCtrl,
  input  logic        bSel,
  input  logic        dmemReq,
  input  logic        dmemReady,
  output logic        pcEn,
  output logic        ifidEn,
  output logic        ifidFlush,
  output logic        idieEn,
  output logic        idieFlush,
  output logic        iedwbEn,
  output logic        memErr,
  output logic [1:0]  state,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt,
  output logic [31:0] freezeCnt
);

  localparam logic [2:0]  ScntInit   = 3'(LOAD_STALL - 1);
  localparam logic [15:0] TmoLimit   = 16'(MEM_TIMEOUT);
  localparam bit          MultiStall = (LOAD_STALL > 1);

  pipe_state_t stateQ;
  pipe_state_t retQ;
  logic [2:0]  scntQ;
  logic [15:0] tmoQ;
  logic        memErrQ;

  logic luHaz;
  logic freeze;
  logic stallReq;

  hazard_detect uHazard (
    .idRs1    (idRs1),
    .idRs2    (idRs2),
    .idUseRs1 (idUseRs1),
    .idUseRs2 (idUseRs2),
    .ieRd     (ieRd),
    .ieRegWR  (ieRegWR),
    .ieWbCtrl (ieWbCtrl),
    .luHaz    (luHaz)
  );

  assign freeze = dmemReq & ~dmemReady;

  // A stall interrupted by a freeze stays pending until the freeze lifts.
  assign stallReq = luHaz || (stateQ == LU_STALL) ||
                    ((stateQ == MEM_WAIT) && (retQ == LU_STALL));

  // Pipeline enables/flushes; priority is freeze, then flush, then stall.
  always_comb begin
    pcEn      = 1'b1;
    ifidEn    = 1'b1;
    ifidFlush = 1'b0;
    idieEn    = 1'b1;
    idieFlush = 1'b0;
    iedwbEn   = 1'b1;
    if (freeze) begin
      pcEn    = 1'b0;
      ifidEn  = 1'b0;
      idieEn  = 1'b0;
      iedwbEn = 1'b0;
    end else if (bSel) begin
      ifidFlush = 1'b1;
      idieFlush = 1'b1;
    end else if (stallReq) begin
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idieFlush = 1'b1;
    end
  end

  // Sequencing FSM with stall counter, freeze timeout and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= RUN;
      retQ    <= RUN;
      scntQ   <= '0;
      tmoQ    <= '0;
      memErrQ <= 1'b0;
    end else begin
      unique case (stateQ)
        RUN: begin
          if (freeze) begin
            stateQ <= MEM_WAIT;
            retQ   <= RUN;
            tmoQ   <= 16'd1;
            if (TmoLimit == 16'd1) memErrQ <= 1'b1;
          end else if (luHaz && !bSel && MultiStall) begin
            stateQ <= LU_STALL;
            scntQ  <= ScntInit;
          end
        end
        LU_STALL: begin
          if (freeze) begin
            // Stall count is held across the freeze.
            stateQ <= MEM_WAIT;
            retQ   <= LU_STALL;
            tmoQ   <= 16'd1;
            if (TmoLimit == 16'd1) memErrQ <= 1'b1;
          end else if (bSel || (scntQ == 3'd1)) begin
            stateQ <= RUN;
            scntQ  <= '0;
          end else begin
            scntQ <= scntQ - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            if (bSel) begin
              stateQ <= RUN;
              scntQ  <= '0;
            end else if (retQ == LU_STALL) begin
              stateQ <= LU_STALL;
            end else if (luHaz && MultiStall) begin
              // Release cycle behaves as a RUN cycle for hazard entry.
              stateQ <= LU_STALL;
              scntQ  <= ScntInit;
            end else begin
              stateQ <= RUN;
            end
          end else begin
            // Saturate so a long freeze cannot wrap the timeout counter.
            if (tmoQ != TmoLimit) tmoQ <= tmoQ + 16'd1;
            if ((tmoQ + 16'd1) == TmoLimit) memErrQ <= 1'b1;
          end
        end
        default: begin
          stateQ <= RUN;
          scntQ  <= '0;
        end
      endcase
    end
  end

  assign state  = stateQ;
  assign memErr = memErrQ;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCntQ;
  logic [31:0] flushCntQ;
  logic [31:0] freezeCntQ;
  logic        stallAct;

  // A stall cycle is one that bubbles ID_IE without a branch flush.
  assign stallAct = idieFlush & ~ifidFlush;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntQ  <= '0;
      flushCntQ  <= '0;
      freezeCntQ <= '0;
    end else begin
      if (stallAct)  stallCntQ  <= stallCntQ + 32'd1;
      if (ifidFlush) flushCntQ  <= flushCntQ + 32'd1;
      if (freeze)    freezeCntQ <= freezeCntQ + 32'd1;
    end
  end

  assign stallCnt  = stallCntQ;
  assign flushCnt  = flushCntQ;
  assign freezeCnt = freezeCntQ;
`else
  assign stallCnt  = '0;
  assign flushCnt  = '0;
  assign freezeCnt = '0;
`endif

endmodule
